// File: rtl/prog_sequencer.sv
// Run controller for the instruction-fetch PC: launches each benchmark program
// at its base address, waits for Halt (or a cycle limit) and reports Done.
module prog_sequencer #(
  parameter int PC_W       = 10,
  parameter int NUM_PROG   = 3,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 256,
  parameter int PROG2_BASE = 512,
  parameter int PROG3_BASE = 768,
  parameter int CYC_W      = 16,
  parameter int MAX_CYC    = 65535
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  output logic             fetch_hold,
  output logic             fetch_jump,
  output logic [PC_W-1:0]  fetch_target,
  output logic             Done,
  output logic             timeout,
  output logic [1:0]       prog_id,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {IDLE, ARMED, LAUNCH, RUN, DONE} state_t;

  localparam logic [CYC_W-1:0] MAX_CNT   = CYC_W'(MAX_CYC);
  localparam logic [CYC_W-1:0] CNT_ONE   = CYC_W'(1);
  localparam logic [1:0]       LAST_PROG = 2'(NUM_PROG - 1);

  state_t           state, state_nxt;
  logic [1:0]       prog_nxt;
  logic [CYC_W-1:0] cnt_nxt;
  logic             timeout_nxt;

  function automatic logic [PC_W-1:0] base_of(input logic [1:0] id);
    case (id)
      2'd0:    base_of = PC_W'(PROG0_BASE);
      2'd1:    base_of = PC_W'(PROG1_BASE);
      2'd2:    base_of = PC_W'(PROG2_BASE);
      default: base_of = PC_W'(PROG3_BASE);
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    prog_nxt    = prog_id;
    cnt_nxt     = cycle_cnt;
    timeout_nxt = timeout;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt   = ARMED;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end
      end
      ARMED: begin
        if (!Start) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        state_nxt = RUN;
        cnt_nxt   = CNT_ONE;
      end
      RUN: begin
        // Halt beats both the limit and an abort request in the same cycle
        if (Halt) begin
          state_nxt = DONE;
          if (cycle_cnt < MAX_CNT) cnt_nxt = cycle_cnt + CNT_ONE;
        end else if (cycle_cnt >= MAX_CNT) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end else if (Start) begin
          state_nxt   = ARMED;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
        end else begin
          cnt_nxt = cycle_cnt + CNT_ONE;
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt   = ARMED;
          cnt_nxt     = '0;
          timeout_nxt = 1'b0;
          prog_nxt    = (prog_id == LAST_PROG) ? 2'd0 : prog_id + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      prog_id      <= 2'd0;
      cycle_cnt    <= '0;
      timeout      <= 1'b0;
      Done         <= 1'b0;
      fetch_hold   <= 1'b1;
      fetch_jump   <= 1'b0;
      fetch_target <= '0;
    end else begin
      state        <= state_nxt;
      prog_id      <= prog_nxt;
      cycle_cnt    <= cnt_nxt;
      timeout      <= timeout_nxt;
      Done         <= (state_nxt == DONE);
      fetch_hold   <= !((state_nxt == LAUNCH) || (state_nxt == RUN));
      fetch_jump   <= (state_nxt == LAUNCH);
      fetch_target <= (state_nxt == LAUNCH) ? base_of(prog_nxt) : '0;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus queues expected launch/done
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_prog_sequencer;

  localparam int PC_W  = 10;
  localparam int CYC_W = 16;

  logic             clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic             Halt = 1'b0;
  logic             fetch_hold;
  logic             fetch_jump;
  logic [PC_W-1:0]  fetch_target;
  logic             Done;
  logic             timeout;
  logic [1:0]       prog_id;
  logic [CYC_W-1:0] cycle_cnt;

  typedef struct {
    bit isDone;
    int prog;
    int target;
    int cnt;
    int to;
  } event_t;

  event_t sbQ[$];
  int checkCount = 0;
  int passCount  = 0;
  bit doneSeen   = 1'b0;

  prog_sequencer #(.PC_W(PC_W), .NUM_PROG(3), .CYC_W(CYC_W), .MAX_CYC(20)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .fetch_hold(fetch_hold), .fetch_jump(fetch_jump), .fetch_target(fetch_target),
    .Done(Done), .timeout(timeout), .prog_id(prog_id), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic s, input logic h, input int n);
    Start = s;
    Halt  = h;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectLaunch(input int prog, input int target);
    sbQ.push_back('{isDone: 1'b0, prog: prog, target: target, cnt: 0, to: 0});
  endtask

  task automatic expectDone(input int prog, input int cnt, input int to);
    sbQ.push_back('{isDone: 1'b1, prog: prog, target: 0, cnt: cnt, to: to});
  endtask

  // From ARMED: release Start, Halt d cycles after LAUNCH; expects cycle_cnt = d+1
  task automatic runProgram(input int prog, input int target, input int d);
    expectLaunch(prog, target);
    expectDone(prog, d + 1, 0);
    applyStimulus(1'b0, 1'b0, 1 + d);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  task automatic handleEvent(input bit isDone);
    event_t e;
    if (sbQ.size() == 0) begin
      checkOutput(isDone ? "unexpectedDone" : "unexpectedLaunch", 1, 0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("eventKind", int'(isDone), int'(e.isDone));
      checkOutput("eventProg", int'(prog_id), e.prog);
      if (isDone) begin
        checkOutput("doneCnt", int'(cycle_cnt), e.cnt);
        checkOutput("doneTimeout", int'(timeout), e.to);
        checkOutput("doneHold", int'(fetch_hold), 1);
      end else begin
        checkOutput("launchTarget", int'(fetch_target), e.target);
        checkOutput("launchCnt", int'(cycle_cnt), 0);
        checkOutput("launchHold", int'(fetch_hold), 0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (Reset) begin
        if (fetch_jump) handleEvent(1'b0);
        if (Done && !doneSeen) handleEvent(1'b1);
      end
      doneSeen = Done;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got 0 expected 1 (simulation time limit)");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("rstHold", int'(fetch_hold), 1);
    checkOutput("rstDone", int'(Done), 0);
    checkOutput("rstJump", int'(fetch_jump), 0);
    checkOutput("rstProg", int'(prog_id), 0);
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2);

    // Start held 3 cycles, halt 5 cycles after LAUNCH
    applyStimulus(1'b1, 1'b0, 3);
    checkOutput("armedHold", int'(fetch_hold), 1);
    runProgram(0, 0, 5);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("doneHoldCnt", int'(cycle_cnt), 6);
    checkOutput("doneLevel", int'(Done), 1);

    // Back-to-back runs through all programs, then wrap
    applyStimulus(1'b1, 1'b0, 1);
    runProgram(1, 256, 3);
    applyStimulus(1'b1, 1'b0, 2);
    runProgram(2, 512, 7);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("wrapProg", int'(prog_id), 0);
    runProgram(0, 0, 2);

    // Async reset in the middle of a run of program 1
    applyStimulus(1'b1, 1'b0, 1);
    expectLaunch(1, 256);
    applyStimulus(1'b0, 1'b0, 4);
    #2 Reset = 1'b0;
    #1;
    checkOutput("asyncRstProg", int'(prog_id), 0);
    checkOutput("asyncRstHold", int'(fetch_hold), 1);
    checkOutput("asyncRstDone", int'(Done), 0);
    checkOutput("asyncRstCnt", int'(cycle_cnt), 0);
    @(posedge clk);
    #1 Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2);

    // Timeout at MAX_CYC=20 with no Halt
    expectLaunch(0, 0);
    expectDone(0, 20, 1);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1);
    for (int i = 0; i < 40 && !Done; i++) applyStimulus(1'b0, 1'b0, 1);
    checkOutput("timeoutReached", int'(Done), 1);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("timeoutHoldCnt", int'(cycle_cnt), 20);
    checkOutput("timeoutHoldFlag", int'(timeout), 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("rearmTimeout", int'(timeout), 0);
    checkOutput("rearmCnt", int'(cycle_cnt), 0);
    checkOutput("rearmProg", int'(prog_id), 1);
    runProgram(1, 256, 4);

    // Abort a run of program 2 and relaunch it
    applyStimulus(1'b1, 1'b0, 2);
    expectLaunch(2, 512);
    applyStimulus(1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("abortDone", int'(Done), 0);
    checkOutput("abortProg", int'(prog_id), 2);
    checkOutput("abortHold", int'(fetch_hold), 1);
    checkOutput("abortCnt", int'(cycle_cnt), 0);
    runProgram(2, 512, 3);

    // Halt ignored in ARMED/LAUNCH; Halt+Start together in RUN
    applyStimulus(1'b1, 1'b1, 2);
    checkOutput("haltArmedDone", int'(Done), 0);
    checkOutput("haltArmedProg", int'(prog_id), 0);
    expectLaunch(0, 0);
    expectDone(0, 4, 0);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("bothDone", int'(Done), 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bothRearmDone", int'(Done), 0);
    checkOutput("bothRearmProg", int'(prog_id), 1);
    runProgram(1, 256, 1);

    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Top-level run controller for the instruction-fetch PC.
- Sequences the benchmark programs 0..NUM_PROG-1 one after another, each on its own Start handshake.
- Drives the fetch unit's hold and absolute-jump controls so each program begins at its base address.
- Detects program completion from the decoder's Halt, reports Done, and times each run for the testbench.

Parameters:
PC_W, 10, program counter / jump target width
NUM_PROG, 3, number of programs in the series (1..4)
PROG0_BASE, 0, first instruction address of program 0
PROG1_BASE, 256, first instruction address of program 1
PROG2_BASE, 512, first instruction address of program 2
PROG3_BASE, 768, first instruction address of program 3
CYC_W, 16, cycle counter width
MAX_CYC, 65535, timeout limit in cycles; must be <= 2^CYC_W-1

Ports:
clk  in  1  system clock, all state changes on rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  testbench request; level, held high then released
Halt  in  1  decoder flag: current instruction is the halt opcode
fetch_hold  out  1  to fetch Start input; 1 freezes the PC
fetch_jump  out  1  to fetch branch_abs; 1 loads fetch_target into the PC
fetch_target  out  PC_W  absolute jump target
Done  out  1  current program has finished; level
timeout  out  1  current run ended by the MAX_CYC limit, not by Halt
prog_id  out  2  index of the program armed, running or just finished
cycle_cnt  out  CYC_W  cycles consumed by the current or last run

Behaviour:
- States: IDLE, ARMED, LAUNCH, RUN, DONE.
- Reset (async, Reset=0), effective at once regardless of state:
  - state=IDLE, prog_id=0, cycle_cnt=0.
  - Done=0, timeout=0, fetch_jump=0, fetch_target=0, fetch_hold=1.
- IDLE:
  - fetch_hold=1.
  - Start=1 -> ARMED.
- ARMED:
  - On entry: cycle_cnt and timeout cleared to 0, Done=0.
  - fetch_hold=1 while Start=1.
  - Start=0 -> LAUNCH.
- LAUNCH (exactly 1 cycle):
  - fetch_hold=0, fetch_jump=1, fetch_target=PROGn_BASE for n=prog_id.
  - cycle_cnt=1 at the end of this cycle.
  - -> RUN.
- RUN:
  - fetch_hold=0, fetch_jump=0, fetch_target=0.
  - cycle_cnt increments every cycle, including the cycle in which Halt is sampled.
  - Halt=1 -> DONE.
  - cycle_cnt==MAX_CYC with Halt=0 -> DONE with timeout=1; the count never exceeds MAX_CYC.
  - Start=1 with Halt=0 -> ARMED (abort): prog_id unchanged, Done stays 0.
  - Halt and Start both 1 in the same cycle: Halt wins (-> DONE); Start is then seen in DONE.
- DONE:
  - fetch_hold=1, Done=1, cycle_cnt and timeout frozen.
  - Start=1 -> ARMED and prog_id advances: prog_id+1, or wraps to 0 when prog_id==NUM_PROG-1.
- Halt is ignored in IDLE, ARMED, LAUNCH and DONE.
- Latency: Start falling edge -> fetch_jump high on the next clock; fetch PC equals the base one cycle later.
- All outputs are registered; no combinational path from an input to an output.

Test Plan:
1. Assert Reset=0 mid-RUN at prog_id=1 -> state IDLE, prog_id=0, fetch_hold=1, Done=0, cycle_cnt=0 immediately, with no clock edge required.
2. Reset release; Start high 3 cycles then low -> fetch_jump=1 for one cycle with fetch_target=0; Halt pulsed 5 cycles after LAUNCH -> Done=1, cycle_cnt=6, timeout=0, fetch_hold=1.
3. Three back-to-back runs -> fetch_target 0, 256, 512 in turn; on the 4th Start, prog_id wraps to 0 and fetch_target=0.
4. MAX_CYC=20, Halt never asserted -> Done=1, timeout=1, cycle_cnt=20 and holding; next Start clears timeout and cycle_cnt.
5. Start raised in RUN at prog_id=2 -> returns to ARMED; after release, relaunch at fetch_target=512 with cycle_cnt restarted from 1.
6. Halt and Start both 1 in the same RUN cycle -> DONE for one cycle (Done=1), then ARMED with prog_id advanced; Halt asserted in ARMED or LAUNCH has no effect.
